// File: rtl/oka_seq_mult.sv
// oka_seq_mult: sequential odd/even Karatsuba multiplier for binary polynomials
// over GF(2). One H x H carry-less product unit is shared by the even, odd and
// mixed sub-products in three consecutive cycles. A fourth cycle recombines them
// into the unreduced 2N-1 bit product.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - operation request; accepted only while busy=0
//   a, b  - N-bit operands, coefficient i in bit i; captured on accept
//   busy  - high while an operation is in flight (4 cycles)
//   done  - one-cycle pulse; y is valid from this cycle on
//   y     - 2N-1 bit carry-less product, held until the next completion
//
// Handshake: start is a request qualified by busy=0. The edge that sees
// start=1 with busy=0 accepts the operands. Exactly four edges later done
// pulses for one cycle. Requests made while busy=1 are dropped, not queued.
// Because busy is already low in the done cycle, a request held there is
// accepted on the next edge, which gives one product every 5 cycles.
module oka_seq_mult #(
    parameter int N = 59
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-2:0] y
);

    localparam int H  = (N + 1) / 2;   // half-operand width
    localparam int AW = 2 * H;         // operand width padded to an even count
    localparam int PW = 2 * H - 1;     // half-size product width
    localparam int VW = 4 * H - 1;     // recombination vector width
    localparam int YW = 2 * N - 1;     // output width

    typedef enum logic [2:0] {
        IDLE,
        MUL_E,
        MUL_O,
        MUL_M,
        COMB
    } state_t;

    state_t state, state_next;

    logic          accept;
    logic [AW-1:0] a_pad, b_pad;
    logic [H-1:0]  ae_in, ao_in, be_in, bo_in;
    logic [H-1:0]  ae, ao, be, bo;
    logic [H-1:0]  mul_a, mul_b;
    logic [PW-1:0] prod;
    logic [PW-1:0] pe, po, pm;
    logic [PW-1:0] mid;
    logic [VW-1:0] vec;
    logic [YW-1:0] y_next;

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start;

    // Next-state logic. Only IDLE waits; the product phases always advance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MUL_E;
            MUL_E:   state_next = MUL_O;
            MUL_O:   state_next = MUL_M;
            MUL_M:   state_next = COMB;
            COMB:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Even/odd coefficient split. For odd N, zero-extending to an even width
    // supplies the missing top odd coefficient as 0.
    always_comb begin
        a_pad = AW'(a);
        b_pad = AW'(b);
        ae_in = '0;
        ao_in = '0;
        be_in = '0;
        bo_in = '0;
        for (int j = 0; j < H; j++) begin
            ae_in[j] = a_pad[2*j];
            ao_in[j] = a_pad[2*j+1];
            be_in[j] = b_pad[2*j];
            bo_in[j] = b_pad[2*j+1];
        end
    end

    // Operand selection for the shared multiplier, one sub-product per state.
    always_comb begin
        mul_a = ae;
        mul_b = be;
        case (state)
            MUL_O: begin
                mul_a = ao;
                mul_b = bo;
            end
            MUL_M: begin
                mul_a = ae ^ ao;
                mul_b = be ^ bo;
            end
            default: begin
                mul_a = ae;
                mul_b = be;
            end
        endcase
    end

    // The single H x H carry-less multiplier (shift-and-xor).
    always_comb begin
        prod = '0;
        for (int i = 0; i < H; i++) begin
            if (mul_a[i]) prod = prod ^ (PW'(mul_b) << i);
        end
    end

    // Recombination: y = Pe(x^2) ^ x*(Pm^Pe^Po)(x^2) ^ x^2*Po(x^2).
    // For odd N the top two bits of vec are always zero, and the cast to YW drops them.
    always_comb begin
        mid = pm ^ pe ^ po;
        vec = '0;
        for (int k = 0; k < PW; k++) begin
            vec[2*k]   = vec[2*k]   ^ pe[k];
            vec[2*k+1] = vec[2*k+1] ^ mid[k];
            vec[2*k+2] = vec[2*k+2] ^ po[k];
        end
        y_next = YW'(vec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            y     <= '0;
            ae    <= '0;
            ao    <= '0;
            be    <= '0;
            bo    <= '0;
            pe    <= '0;
            po    <= '0;
            pm    <= '0;
        end else begin
            state <= state_next;
            done  <= (state == COMB);
            if (accept) begin
                ae <= ae_in;
                ao <= ao_in;
                be <= be_in;
                bo <= bo_in;
            end
            case (state)
                MUL_E:   pe <= prod;
                MUL_O:   po <= prod;
                MUL_M:   pm <= prod;
                COMB:    y  <= y_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oka_seq_mult.sv
module tb_oka_seq_mult;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         start59 = 1'b0;
    logic [58:0]  a59 = '0;
    logic [58:0]  b59 = '0;
    logic         busy59;
    logic         done59;
    logic [116:0] y59;

    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         busy8;
    logic         done8;
    logic [14:0]  y8;

    int checks   = 0;
    int failures = 0;

    logic [116:0] exp59_q[$];
    logic [14:0]  exp8_q[$];

    always #5 clk = ~clk;

    oka_seq_mult #(.N(59)) dut59 (
        .clk(clk), .rst(rst), .start(start59), .a(a59), .b(b59),
        .busy(busy59), .done(done59), .y(y59)
    );

    oka_seq_mult #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .y(y8)
    );

    // Reference models: plain bitwise carry-less products.
    function automatic logic [116:0] ref59(input logic [58:0] x, input logic [58:0] z);
        logic [116:0] r;
        r = '0;
        for (int i = 0; i < 59; i++) if (x[i]) r = r ^ (117'(z) << i);
        return r;
    endfunction

    function automatic logic [14:0] ref8(input logic [7:0] x, input logic [7:0] z);
        logic [14:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (x[i]) r = r ^ (15'(z) << i);
        return r;
    endfunction

    // Driver tasks. Called at a falling edge; return at the falling edge after the accept.
    task automatic start59_op(input logic [58:0] av, input logic [58:0] bv);
        start59 = 1'b1;
        a59 = av;
        b59 = bv;
        exp59_q.push_back(ref59(av, bv));
        @(negedge clk);
        start59 = 1'b0;
    endtask

    task automatic start8_op(input logic [7:0] av, input logic [7:0] bv);
        start8 = 1'b1;
        a8 = av;
        b8 = bv;
        exp8_q.push_back(ref8(av, bv));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Waits (bounded) for done, counting falling edges and busy-high samples.
    task automatic wait_done59(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (done59 !== 1'b1 && cyc < 20) begin
            if (busy59 === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy59 !== 1'b0) begin failures++; $display("FAIL reset_busy59 got=%b exp=0", busy59); end
        checks++; if (done59 !== 1'b0) begin failures++; $display("FAIL reset_done59 got=%b exp=0", done59); end
        checks++; if (y59 !== 117'd0) begin failures++; $display("FAIL reset_y59 got=%h exp=0", y59); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        checks++; if (y8 !== 15'd0) begin failures++; $display("FAIL reset_y8 got=%h exp=0", y8); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc, bc;
        logic [116:0] e;
        start59_op(59'd1, 59'd1);
        wait_done59(cyc, bc);
        e = exp59_q.pop_front();
        checks++; if (cyc != 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", cyc); end
        checks++; if (bc != 4) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
        checks++; if (y59 !== e) begin failures++; $display("FAIL basic_y_model got=%h exp=%h", y59, e); end
        checks++; if (y59 !== 117'd1) begin failures++; $display("FAIL basic_y got=%h exp=1", y59); end
        @(negedge clk);
        checks++; if (done59 !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", done59); end
        checks++; if (y59 !== 117'd1) begin failures++; $display("FAIL basic_y_hold got=%h exp=1", y59); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        logic [116:0] e;
        start59_op(59'h7, 59'h7);
        wait_done59(cyc, bc);
        e = exp59_q.pop_front();
        checks++; if (y59 !== 117'h15) begin failures++; $display("FAIL b2b_first_y got=%h exp=15", y59); end
        checks++; if (y59 !== e) begin failures++; $display("FAIL b2b_first_model got=%h exp=%h", y59, e); end
        // Request issued in the done cycle itself.
        start59_op(59'h3, 59'h3);
        wait_done59(cyc, bc);
        e = exp59_q.pop_front();
        checks++; if (cyc + 1 != 5) begin failures++; $display("FAIL b2b_gap got=%0d exp=5", cyc + 1); end
        checks++; if (y59 !== 117'h5) begin failures++; $display("FAIL b2b_second_y got=%h exp=5", y59); end
        checks++; if (y59 !== e) begin failures++; $display("FAIL b2b_second_model got=%h exp=%h", y59, e); end
    endtask

    task automatic test_top_bit();
        int cyc, bc;
        logic [58:0] t;
        logic [116:0] e, c;
        t = 59'd1 << 58;
        c = 117'd1 << 116;
        start59_op(t, t);
        wait_done59(cyc, bc);
        e = exp59_q.pop_front();
        checks++; if (y59 !== c) begin failures++; $display("FAIL top_bit_y got=%h exp=%h", y59, c); end
        checks++; if (y59 !== e) begin failures++; $display("FAIL top_bit_model got=%h exp=%h", y59, e); end
    endtask

    task automatic test_even_n();
        int cyc;
        logic [14:0] e;
        start8_op(8'hFF, 8'hFF);
        wait_done8(cyc);
        e = exp8_q.pop_front();
        checks++; if (cyc != 4) begin failures++; $display("FAIL even_latency got=%0d exp=4", cyc); end
        checks++; if (y8 !== 15'h5555) begin failures++; $display("FAIL even_y got=%h exp=5555", y8); end
        checks++; if (y8 !== e) begin failures++; $display("FAIL even_model got=%h exp=%h", y8, e); end
    endtask

    task automatic test_ignore_busy();
        int dcnt;
        logic [116:0] ycap, e;
        dcnt = 0;
        ycap = '0;
        start59_op(59'h1234567, 59'h3);
        // Hold start high with fresh operands across edges k+1..k+4.
        start59 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a59 = 59'({$urandom(), $urandom()});
            b59 = 59'({$urandom(), $urandom()});
            @(negedge clk);
            if (done59 === 1'b1) begin
                dcnt++;
                ycap = y59;
            end
        end
        start59 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done59 === 1'b1) dcnt++;
        end
        e = exp59_q.pop_front();
        checks++; if (dcnt != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dcnt); end
        checks++; if (ycap !== e) begin failures++; $display("FAIL ignore_y got=%h exp=%h", ycap, e); end
        checks++; if (busy59 !== 1'b0) begin failures++; $display("FAIL ignore_idle got=%b exp=0", busy59); end
    endtask

    task automatic test_reset_mid();
        int dcnt, cyc, bc;
        logic [116:0] e;
        dcnt = 0;
        start59_op(59'h5, 59'h3);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        void'(exp59_q.pop_back());
        checks++; if (busy59 !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy59); end
        checks++; if (y59 !== 117'd0) begin failures++; $display("FAIL rst_mid_y got=%h exp=0", y59); end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done59 === 1'b1) dcnt++;
        end
        checks++; if (dcnt != 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", dcnt); end
        start59_op(59'h5, 59'h3);
        wait_done59(cyc, bc);
        e = exp59_q.pop_front();
        checks++; if (cyc != 4) begin failures++; $display("FAIL rst_mid_latency got=%0d exp=4", cyc); end
        checks++; if (y59 !== 117'hF) begin failures++; $display("FAIL rst_mid_y_after got=%h exp=f", y59); end
        checks++; if (y59 !== e) begin failures++; $display("FAIL rst_mid_model got=%h exp=%h", y59, e); end
    endtask

    task automatic test_random();
        int cyc, bc;
        logic [116:0] e59;
        logic [14:0]  e8;
        logic [58:0]  av, bv;
        logic [7:0]   av8, bv8;
        for (int n = 0; n < 10000; n++) begin
            av  = 59'({$urandom(), $urandom()});
            bv  = 59'({$urandom(), $urandom()});
            av8 = 8'($urandom_range(0, 255));
            bv8 = 8'($urandom_range(0, 255));
            if (n == 0) begin av = '1; bv = '1; av8 = '1; bv8 = 8'h80; end
            start59 = 1'b1; a59 = av;  b59 = bv;
            start8  = 1'b1; a8  = av8; b8  = bv8;
            exp59_q.push_back(ref59(av, bv));
            exp8_q.push_back(ref8(av8, bv8));
            @(negedge clk);
            start59 = 1'b0;
            start8  = 1'b0;
            wait_done59(cyc, bc);
            e59 = exp59_q.pop_front();
            e8  = exp8_q.pop_front();
            checks++; if (cyc != 4) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=4", n, cyc); end
            checks++; if (done8 !== 1'b1) begin failures++; $display("FAIL rand_done8 n=%0d got=%b exp=1", n, done8); end
            checks++; if (y59 !== e59) begin failures++; $display("FAIL rand_y59 n=%0d a=%h b=%h got=%h exp=%h", n, av, bv, y59, e59); end
            checks++; if (y8 !== e8) begin failures++; $display("FAIL rand_y8 n=%0d a=%h b=%h got=%h exp=%h", n, av8, bv8, y8, e8); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_top_bit();
        test_even_n();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
